// File: rtl/remote_comm_pkg.sv
// Shared constants and types for the host-side robot command link.
package remote_comm_pkg;

    // 50 MHz clock, 19200 baud
    localparam int BAUD_CYCLES_DEF = 2604;

    // Well-known commands and responses exchanged with the robot
    localparam logic [15:0] CAL_GYRO = 16'h2000;
    localparam logic [3:0]  OP_MOVE  = 4'h4;
    localparam logic [3:0]  OP_TOUR  = 4'h6;
    localparam logic [7:0]  POS_ACK  = 8'hA5;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_HIGH = 2'd1,
        CMD_LOW  = 2'd2
    } cmd_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

    // 8N1 frame, shifted out LSB first: start bit, data LSB..MSB, stop bit
    function automatic logic [9:0] uart_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart.sv
// 8N1 UART: independent transmitter and receiver sharing one clock.
module uart
    import remote_comm_pkg::*;
#(
    parameter int BAUD_CYCLES = BAUD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    // transmitter
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    // receiver
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rdy,
    input  logic       clr_rdy
);

    localparam int CW = $clog2(BAUD_CYCLES + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CYCLES / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // ---------------- transmitter ----------------
    logic          tx_busy_q;
    logic [9:0]    tx_shift_q;
    logic [CW-1:0] tx_baud_q;
    logic [3:0]    tx_bit_q;
    logic          tx_done_q;
    logic          tx_bit_end_d;

    assign tx_bit_end_d = tx_busy_q && (tx_baud_q == BAUD_LAST);
    assign TX           = tx_shift_q[0];
    assign tx_done      = tx_done_q;

    // Load a frame on trmt, shift one bit per baud period, pulse done after the stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (trmt && !tx_busy_q) begin
                tx_busy_q  <= 1'b1;
                tx_shift_q <= uart_frame(tx_data);
                tx_baud_q  <= '0;
                tx_bit_q   <= '0;
            end else if (tx_busy_q) begin
                if (tx_bit_end_d) begin
                    tx_baud_q  <= '0;
                    tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                    // tenth bit period (stop bit) just finished
                    if (tx_bit_q == 4'd9) begin
                        tx_busy_q <= 1'b0;
                        tx_done_q <= 1'b1;
                    end
                end else begin
                    tx_baud_q <= tx_baud_q + CNT_ONE;
                end
            end
        end
    end

    // ---------------- receiver ----------------
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    rx_state_t     rx_state_q;
    logic [CW-1:0] rx_baud_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_data_q;
    logic          rdy_q;
    logic          rx_start_d;
    logic          rx_sample_d;
    logic          rx_done_d;

    assign rx_start_d  = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;
    assign rx_sample_d = (rx_state_q == RX_RECV) && (rx_baud_q == '0);
    assign rx_done_d   = rx_sample_d && (rx_bit_q == 4'd9) && (rx_state_q == RX_RECV);
    assign rx_data     = rx_data_q;
    assign rdy         = rdy_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle line is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Sample mid-bit: half a period after the start edge, then every full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_start_d) begin
                        rx_state_q <= RX_RECV;
                        rx_baud_q  <= HALF_LAST;
                        rx_bit_q   <= '0;
                    end
                end
                RX_RECV: begin
                    if (rx_baud_q != '0) begin
                        rx_baud_q <= rx_baud_q - CNT_ONE;
                    end else begin
                        rx_baud_q <= BAUD_LAST;
                        rx_bit_q  <= rx_bit_q + 4'd1;
                        if (rx_bit_q == 4'd0) begin
                            // line back high at the start-bit centre: it was a glitch
                            if (rx_sync_q) begin
                                rx_state_q <= RX_IDLE;
                            end
                        end else if (rx_bit_q == 4'd9) begin
                            // stop sample: the byte is delivered whatever the stop level
                            rx_data_q  <= rx_shift_q;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Ready flag: set on frame completion (takes priority), cleared by a new start edge or clr_rdy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else if (rx_done_d) begin
            rdy_q <= 1'b1;
        end else if (clr_rdy || rx_start_d) begin
            rdy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/remote_comm.sv
// Host-side command link: sends a 16-bit command as two UART bytes (high first)
// and reports the robot's one-byte response.
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_CYCLES = BAUD_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    cmd_state_t state_q;
    logic [7:0] low_byte_q;
    logic [7:0] tx_data_q;
    logic       trmt_q;
    logic       cmd_snt_q;
    logic       tx_done;

    assign cmd_snt = cmd_snt_q;

    // Command sequencer: high byte, then the latched low byte, then flag completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CMD_IDLE;
            low_byte_q <= '0;
            tx_data_q  <= '0;
            trmt_q     <= 1'b0;
            cmd_snt_q  <= 1'b0;
        end else begin
            trmt_q <= 1'b0;
            case (state_q)
                CMD_IDLE: begin
                    if (snd_cmd) begin
                        low_byte_q <= cmd[7:0];
                        tx_data_q  <= cmd[15:8];
                        trmt_q     <= 1'b1;
                        cmd_snt_q  <= 1'b0;
                        state_q    <= CMD_HIGH;
                    end
                end
                CMD_HIGH: begin
                    if (tx_done) begin
                        tx_data_q <= low_byte_q;
                        trmt_q    <= 1'b1;
                        state_q   <= CMD_LOW;
                    end
                end
                CMD_LOW: begin
                    if (tx_done) begin
                        cmd_snt_q <= 1'b1;
                        state_q   <= CMD_IDLE;
                    end
                end
                default: state_q <= CMD_IDLE;
            endcase
        end
    end

    uart #(
        .BAUD_CYCLES(BAUD_CYCLES)
    ) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt_q),
        .tx_data (tx_data_q),
        .TX      (TX),
        .tx_done (tx_done),
        .RX      (RX),
        .rx_data (resp),
        .rdy     (resp_rdy),
        .clr_rdy (snd_cmd)
    );

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm with a shortened bit time.
module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int B = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        snd_cmd = 1'b0;
    logic        RX = 1'b1;
    logic        cmd_snt;
    logic        TX;
    logic [7:0]  resp;
    logic        resp_rdy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] rb0, rb1;
    logic       rok0, rok1;
    int         lat;
    int         t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    remote_comm #(.BAUD_CYCLES(B)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .cmd_snt  (cmd_snt),
        .TX       (TX),
        .RX       (RX),
        .resp     (resp),
        .resp_rdy (resp_rdy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_snd(input logic [15:0] c);
        cmd = c;
        snd_cmd = 1'b1;
        tick(1);
        snd_cmd = 1'b0;
    endtask

    // Reference receiver on TX: find the start edge, sample each bit at its centre
    task automatic ref_rx(output logic [7:0] b, output logic ok);
        int n;
        n = 0;
        ok = 1'b0;
        b = 8'h00;
        while (TX !== 1'b0 && n < 30 * B) begin
            tick(1);
            n++;
        end
        if (TX !== 1'b0) return;
        tick(B / 2);
        if (TX !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            tick(B);
            b[i] = TX;
        end
        tick(B);
        ok = (TX === 1'b1);
    endtask

    task automatic drive_rx(input logic [7:0] d);
        RX = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            tick(B);
        end
        RX = 1'b1;
        tick(B);
    endtask

    task automatic wait_rdy(output int latency);
        int n;
        n = 0;
        while (resp_rdy !== 1'b1 && n < 12 * B) begin
            tick(1);
            n++;
        end
        latency = (resp_rdy === 1'b1) ? n : -1;
    endtask

    task automatic wait_snt(output int latency);
        int n;
        n = 0;
        while (cmd_snt !== 1'b1 && n < 4 * B) begin
            tick(1);
            n++;
        end
        latency = (cmd_snt === 1'b1) ? (cyc - t0) : -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        total++;
        if ({TX, cmd_snt, resp_rdy, resp} !== {3'b100, 8'h00}) begin
            $display("FAIL reset_values: got TX=%b cmd_snt=%b resp_rdy=%b resp=%h required 1 0 0 00",
                     TX, cmd_snt, resp_rdy, resp);
        end else passed++;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            total++;
            if ({TX, cmd_snt, resp_rdy} !== 3'b100) begin
                $display("FAIL idle_cycle_%0d: got TX=%b cmd_snt=%b resp_rdy=%b required 1 0 0",
                         i, TX, cmd_snt, resp_rdy);
            end else passed++;
        end
        $display("reset: idle 100 cycles checked");
    endtask

    task automatic test_send_cmd;
        pulse_snd(16'h6033);
        t0 = cyc;
        total++;
        if (cmd_snt !== 1'b0) $display("FAIL snt_low_after_send: got %b required 0", cmd_snt);
        else passed++;
        ref_rx(rb0, rok0);
        ref_rx(rb1, rok1);
        total++;
        if ({rok0, rb0} !== {1'b1, 8'h60}) $display("FAIL tx_high_6033: got ok=%b byte=%h required 1 60", rok0, rb0);
        else passed++;
        total++;
        if ({rok1, rb1} !== {1'b1, 8'h33}) $display("FAIL tx_low_6033: got ok=%b byte=%h required 1 33", rok1, rb1);
        else passed++;
        total++;
        if (cmd_snt !== 1'b0) $display("FAIL snt_early: got %b required 0 during stop bit", cmd_snt);
        else passed++;
        wait_snt(lat);
        total++;
        if (lat < 20 * B || lat > 20 * B + 8)
            $display("FAIL snt_latency: got %0d cycles required %0d..%0d", lat, 20 * B, 20 * B + 8);
        else passed++;
        tick(20);
        total++;
        if (cmd_snt !== 1'b1) $display("FAIL snt_holds: got %b required 1", cmd_snt);
        else passed++;
        $display("send 6033: bytes %h %h, cmd_snt after %0d cycles", rb0, rb1, lat);
    endtask

    task automatic test_rx_resp;
        t0 = cyc;
        fork
            drive_rx(POS_ACK);
            wait_rdy(lat);
        join
        total++;
        if (lat < (19 * B) / 2 || lat > (19 * B) / 2 + 8)
            $display("FAIL rx_latency: got %0d cycles required %0d..%0d", lat, (19 * B) / 2, (19 * B) / 2 + 8);
        else passed++;
        total++;
        if (resp !== 8'hA5) $display("FAIL rx_resp_a5: got %h required a5", resp);
        else passed++;
        tick(50);
        total++;
        if ({resp_rdy, resp} !== {1'b1, 8'hA5})
            $display("FAIL rx_rdy_holds: got rdy=%b resp=%h required 1 a5", resp_rdy, resp);
        else passed++;
        $display("rx a5: resp=%h rdy after %0d cycles", resp, lat);
    endtask

    task automatic test_glitch;
        RX = 1'b0;
        tick((3 * B) / 10);
        RX = 1'b1;
        tick(4);
        total++;
        if (resp_rdy !== 1'b0) $display("FAIL glitch_clears_rdy: got %b required 0", resp_rdy);
        else passed++;
        tick(2 * B);
        total++;
        if ({resp_rdy, resp} !== {1'b0, 8'hA5})
            $display("FAIL glitch_rejected: got rdy=%b resp=%h required 0 a5", resp_rdy, resp);
        else passed++;
        fork
            drive_rx(8'h5A);
            wait_rdy(lat);
        join
        total++;
        if ({resp_rdy, resp} !== {1'b1, 8'h5A} || lat < 0)
            $display("FAIL rx_after_glitch: got rdy=%b resp=%h required 1 5a", resp_rdy, resp);
        else passed++;
        $display("glitch then 5a: resp=%h", resp);
    endtask

    task automatic test_back_to_back;
        int lows;
        pulse_snd(CAL_GYRO);
        t0 = cyc;
        total++;
        if ({cmd_snt, resp_rdy} !== 2'b00)
            $display("FAIL snd_clears_flags: got cmd_snt=%b resp_rdy=%b required 0 0", cmd_snt, resp_rdy);
        else passed++;
        fork
            begin
                ref_rx(rb0, rok0);
                ref_rx(rb1, rok1);
            end
            begin
                tick(3 * B);
                pulse_snd(16'hFFFF);
            end
        join
        total++;
        if ({rok0, rb0} !== {1'b1, 8'h20}) $display("FAIL tx_high_2000: got ok=%b byte=%h required 1 20", rok0, rb0);
        else passed++;
        total++;
        if ({rok1, rb1} !== {1'b1, 8'h00}) $display("FAIL tx_low_2000: got ok=%b byte=%h required 1 00", rok1, rb1);
        else passed++;
        wait_snt(lat);
        total++;
        if (lat < 20 * B || lat > 20 * B + 8)
            $display("FAIL snt_latency_2000: got %0d cycles required %0d..%0d", lat, 20 * B, 20 * B + 8);
        else passed++;
        lows = 0;
        for (int i = 0; i < 12 * B; i++) begin
            tick(1);
            if (TX !== 1'b1) lows++;
        end
        total++;
        if (lows !== 0) $display("FAIL no_third_byte: got %0d low TX cycles required 0", lows);
        else passed++;
        $display("send 2000 with ignored pulse: bytes %h %h", rb0, rb1);
    endtask

    task automatic test_reset_mid;
        int n;
        pulse_snd({OP_MOVE, 12'h001});
        n = 0;
        while (TX !== 1'b0 && n < 4 * B) begin
            tick(1);
            n++;
        end
        tick(2 * B);
        total++;
        if (TX !== 1'b0) $display("FAIL mid_byte_low: got TX=%b required 0", TX);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({TX, cmd_snt, resp_rdy} !== 3'b100)
            $display("FAIL async_reset: got TX=%b cmd_snt=%b resp_rdy=%b required 1 0 0", TX, cmd_snt, resp_rdy);
        else passed++;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        total++;
        if (TX !== 1'b1) $display("FAIL idle_after_reset: got TX=%b required 1", TX);
        else passed++;
        pulse_snd(16'h4001);
        t0 = cyc;
        ref_rx(rb0, rok0);
        ref_rx(rb1, rok1);
        total++;
        if ({rok0, rb0} !== {1'b1, 8'h40}) $display("FAIL tx_high_4001: got ok=%b byte=%h required 1 40", rok0, rb0);
        else passed++;
        total++;
        if ({rok1, rb1} !== {1'b1, 8'h01}) $display("FAIL tx_low_4001: got ok=%b byte=%h required 1 01", rok1, rb1);
        else passed++;
        wait_snt(lat);
        total++;
        if (lat < 20 * B || lat > 20 * B + 8)
            $display("FAIL snt_latency_4001: got %0d cycles required %0d..%0d", lat, 20 * B, 20 * B + 8);
        else passed++;
        $display("reset mid-byte then 4001: bytes %h %h", rb0, rb1);
    endtask

    initial begin
        test_reset();
        test_send_cmd();
        test_rx_resp();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/remote_comm.md
Name: remote_comm

Overview:
Host-side command link for the Knight robot bench and remote controller. Accepts a 16-bit command and serialises it over UART (8N1) as two bytes, high byte first, on TX. Independently receives a one-byte response from the robot on RX and presents it with a ready flag. Sits between the host/test stimulus and the robot's UART command processor.

Parameters:
BAUD_CYCLES, 2604, clocks per UART bit; 50 MHz / 19200 baud.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd  input  16  command to transmit; [15:12] opcode, [11:0] operands
snd_cmd  input  1  single-cycle request to start transmitting cmd
cmd_snt  output  1  high once both bytes of the last command have left TX; level
TX  output  1  UART serial out to robot; idles high
RX  input  1  UART serial in from robot; asynchronous
resp  output  8  last response byte received
resp_rdy  output  1  high when resp holds a fresh byte

Behaviour:
- Reset values:
  - TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00.
  - Both RX synchroniser flops preset to 1.
  - All FSMs in IDLE.
- Frame format:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Every bit lasts exactly BAUD_CYCLES clocks.
- Command FSM states: IDLE, HIGH, LOW.
  - IDLE:
    - On snd_cmd, latch cmd[7:0] into a low-byte register.
    - Load cmd[15:8] into the transmitter and start it.
    - Clear cmd_snt in the same edge.
    - Go to HIGH.
  - HIGH: when the transmitter signals done (end of stop bit), load the low byte, start it, go to LOW.
  - LOW: when the transmitter signals done, set cmd_snt, go to IDLE.
  - Gap between the high stop bit and the low start bit is at most 2 clocks.
- snd_cmd while not in IDLE is ignored. The cmd value is captured only at snd_cmd, so later changes to cmd have no effect.
- Transmitter:
  - Shift register of 10 bits; TX is driven from its LSB.
  - Baud counter and bit counter (0..10).
  - done pulses one clock after the 10th bit period completes.
- Receiver:
  - RX passes through a 2-flop synchroniser.
  - Start condition is a falling edge of the synchronised RX while idle.
  - First sample at BAUD_CYCLES/2 after the edge confirms the start bit. If RX is high at that sample, abort to idle (glitch rejection).
  - Each subsequent bit is sampled every BAUD_CYCLES. Data bits shift in LSB first.
  - After 8 data bits plus the stop sample:
    - Load resp and set resp_rdy.
    - A stop bit sampled low still loads resp (no framing error output).
- resp_rdy clears on detection of the next start bit, or on snd_cmd; it otherwise holds.
- If snd_cmd and stop-sample completion occur in the same cycle, completion wins: resp_rdy=1.
- Reset asserted mid-frame aborts immediately to the reset values; TX returns high asynchronously.
- TX and RX paths are fully independent and may operate simultaneously.

Decomposition:
- Shared package: BAUD_CYCLES default; command constants CAL_GYRO=16'h2000, MOVE opcode 4'h4, TOUR opcode 4'h6; POS_ACK=8'hA5.
- One sub-module, uart, holding:
  - the transmitter (trmt, tx_data, TX, tx_done);
  - the receiver (RX, rx_data, rdy, clr_rdy).
- remote_comm contains only the command FSM and the low-byte register.

Test Plan:
- Reset, then idle 100 clocks -> TX=1, cmd_snt=0, resp_rdy=0 throughout.
- snd_cmd with cmd=16'h6033 -> TX carries byte 0x60 then byte 0x33, each decoded by a reference UART receiver. cmd_snt rises about 20*BAUD_CYCLES clocks after snd_cmd. cmd_snt falls on the next snd_cmd.
- Drive RX with frame 0xA5 -> resp=8'hA5, resp_rdy=1 at about 9.5 bit times after the start edge. resp_rdy stays 1 until a new RX start bit arrives.
- 0.3-bit low glitch on RX -> no resp_rdy; receiver returns to idle and then correctly receives a following 0x5A frame.
- snd_cmd of 16'h2000 pulsed again during transmission of the HIGH byte -> second pulse ignored; exactly two bytes, 0x20 and 0x00, are sent.
- Assert rst_n low mid-byte -> TX=1 immediately. After release, a new snd_cmd with 16'h4001 transmits cleanly.
